// File: rtl/test_out_pkg.sv
// Shared types and constants for the test-word UART trace path.
package test_out_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BITS_PER_BYTE  = 8;

    // Ceiling log2 for sizing counters and pointers (returns 0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/test_out_fifo.sv
// Capture FIFO for test words; head entry is visible combinationally on dout.
module test_out_fifo
    import test_out_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [31:0]           din,
    input  logic                  pop,
    output logic [31:0]           dout,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] level
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   LVL_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   LVL_DEPTH = (AW + 1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_DEPTH);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)      level <= level + LVL_ONE;
            else if (do_pop && !do_push) level <= level - LVL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/test_out_uart_tx.sv
// Captures changes of the CPU test word and streams each one as four 8N1 frames, LSB byte first.
module test_out_uart_tx
    import test_out_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       capture_en,
    input  logic [31:0]                test_data_in,
    input  logic                       clear_overflow,
    output logic                       tx,
    output logic                       busy,
    output logic [clog2(FIFO_DEPTH):0] fifo_level,
    output logic                       overflow,
    output logic [7:0]                 drop_count
);

    localparam int BAUD_W = clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [2:0]        BIT_LAST  = 3'(BITS_PER_BYTE - 1);
    localparam logic [1:0]        BYTE_LAST = 2'(BYTES_PER_WORD - 1);

    logic [31:0]       prev_q;
    logic [31:0]       word_q;
    logic [31:0]       fifo_dout;
    logic              change;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              drop;

    tx_state_t         state;
    tx_state_t         state_d;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_d;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_d;
    logic [1:0]        byte_idx;
    logic [1:0]        byte_d;
    logic              tx_d;

    assign change   = capture_en && (test_data_in != prev_q);
    assign fifo_pop = (state == IDLE) && !fifo_empty;
    assign drop     = change && fifo_full && !fifo_pop;
    assign busy     = (state != IDLE);

    test_out_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (change),
        .din   (test_data_in),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev_q <= '0;
        else      prev_q <= test_data_in;
    end

    // Clearing wins over a drop landing in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_pop) word_q <= fifo_dout;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_idx  <= bit_d;
            byte_idx <= byte_d;
            tx       <= tx_d;
        end
    end

    // tx_d reflects the current state, so the line lags the FSM by one registered cycle.
    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_idx;
        byte_d  = byte_idx;
        tx_d    = 1'b1;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = START;
                    baud_d  = '0;
                    byte_d  = '0;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_cnt == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_cnt + BAUD_ONE;
                end
            end
            DATA: begin
                tx_d = word_q[{byte_idx, bit_idx}];
                if (baud_cnt == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_idx == BIT_LAST) state_d = STOP;
                    else                     bit_d   = bit_idx + 3'd1;
                end else begin
                    baud_d = baud_cnt + BAUD_ONE;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_cnt == BAUD_LAST) begin
                    baud_d = '0;
                    if (byte_idx == BYTE_LAST) begin
                        state_d = IDLE;
                    end else begin
                        byte_d  = byte_idx + 2'd1;
                        state_d = START;
                    end
                end else begin
                    baud_d = baud_cnt + BAUD_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_test_out_uart_tx.sv
// Directed bench for test_out_uart_tx with CLKS_PER_BIT=4 and a 4-entry FIFO.
module tb_test_out_uart_tx;

    localparam int CPB     = 4;
    localparam int DEPTH   = 4;
    localparam int REC_MAX = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        capture_en = 1'b0;
    logic        clear_overflow = 1'b0;
    logic [31:0] test_data_in = '0;
    logic        tx;
    logic        busy;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic        rec_on = 1'b0;
    int          rec_n  = 0;
    logic        rec_tx   [REC_MAX];
    logic        rec_busy [REC_MAX];
    logic [2:0]  rec_lvl  [REC_MAX];
    logic [31:0] dec_words [16];
    int          dec_n;
    int          dec_ferr;

    test_out_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .capture_en     (capture_en),
        .test_data_in   (test_data_in),
        .clear_overflow (clear_overflow),
        .tx             (tx),
        .busy           (busy),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    // Sample index c holds the outputs just after the c-th rising edge since recording began.
    always @(posedge clk) begin
        #2;
        if (!rec_on) begin
            rec_n = 0;
        end else if (rec_n < REC_MAX) begin
            rec_tx[rec_n]   = tx;
            rec_busy[rec_n] = busy;
            rec_lvl[rec_n]  = fifo_level;
            rec_n++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    // Independent UART receiver over the recorded line: start low, 8 data bits LSB first, stop high.
    task automatic decode_rec();
        int p;
        int nb;
        logic [7:0]  b;
        logic [31:0] acc;
        dec_n = 0; dec_ferr = 0; nb = 0; p = 0; acc = '0;
        while (p + 40 <= rec_n) begin
            if (rec_tx[p] === 1'b0) begin
                if (rec_tx[p + 2] !== 1'b0) dec_ferr++;
                for (int k = 0; k < 8; k++) b[k] = rec_tx[p + 6 + 4 * k];
                if (rec_tx[p + 38] !== 1'b1) dec_ferr++;
                acc[8 * nb +: 8] = b;
                nb++;
                if (nb == 4) begin
                    if (dec_n < 16) dec_words[dec_n] = acc;
                    dec_n++;
                    nb = 0;
                end
                p += 40;
            end else begin
                p++;
            end
        end
        if (nb != 0) dec_ferr++;
    endtask

    task automatic do_reset();
        rec_on = 1'b0;
        @(negedge clk);
        rst = 1'b0; capture_en = 1'b1; clear_overflow = 1'b0; test_data_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; capture_en = 1'b1; test_data_in = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_release_tx: got %b expected 1", tx); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single_word();
        logic [7:0] exp_b [4];
        logic [7:0] got;
        int nbusy;
        int max_lvl;
        int lows;
        int s;
        logic edges_ok;
        exp_b = '{8'h78, 8'h56, 8'h34, 8'h12};
        do_reset();
        test_data_in = 32'h12345678;
        rec_on = 1'b1;
        repeat (170) @(negedge clk);
        n_checks++; if (rec_tx[1] !== 1'b1) begin n_fail++; $display("FAIL single_tx_c1: got %b expected 1", rec_tx[1]); end
        n_checks++; if (rec_tx[2] !== 1'b0) begin n_fail++; $display("FAIL single_start_latency: got %b expected 0", rec_tx[2]); end
        n_checks++; if ({rec_busy[0], rec_busy[1]} !== 2'b01) begin n_fail++; $display("FAIL single_busy_rise: got %b%b expected 01", rec_busy[0], rec_busy[1]); end
        nbusy = 0; max_lvl = 0; lows = 0;
        for (int c = 0; c < 170; c++) begin
            if (rec_busy[c] === 1'b1) nbusy++;
            if (int'(rec_lvl[c]) > max_lvl) max_lvl = int'(rec_lvl[c]);
            if (c >= 162 && rec_tx[c] !== 1'b1) lows++;
        end
        n_checks++; if (nbusy != 160) begin n_fail++; $display("FAIL single_busy_cycles: got %0d expected 160", nbusy); end
        n_checks++; if ({rec_busy[160], rec_busy[161]} !== 2'b10) begin n_fail++; $display("FAIL single_busy_fall: got %b%b expected 10", rec_busy[160], rec_busy[161]); end
        n_checks++; if (max_lvl != 1) begin n_fail++; $display("FAIL single_level_peak: got %0d expected 1", max_lvl); end
        n_checks++; if (lows != 0) begin n_fail++; $display("FAIL single_idle_after: got %0d non-idle cycles expected 0", lows); end
        for (int b = 0; b < 4; b++) begin
            s = 2 + 40 * b;
            edges_ok = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (rec_tx[s + k] !== 1'b0) edges_ok = 1'b0;
                if (rec_tx[s + 36 + k] !== 1'b1) edges_ok = 1'b0;
            end
            for (int k = 0; k < 8; k++) got[k] = rec_tx[s + 4 + 4 * k + 2];
            n_checks++; if (got !== exp_b[b]) begin n_fail++; $display("FAIL single_frame%0d_byte: got %h expected %h", b, got, exp_b[b]); end
            n_checks++; if (edges_ok !== 1'b1) begin n_fail++; $display("FAIL single_frame%0d_start_stop: got %b expected 1", b, edges_ok); end
        end
        rec_on = 1'b0;
        decode_rec();
        n_checks++; if (dec_n != 1) begin n_fail++; $display("FAIL single_word_count: got %0d expected 1", dec_n); end
        n_checks++; if (dec_words[0] !== 32'h12345678) begin n_fail++; $display("FAIL single_word_value: got %h expected 12345678", dec_words[0]); end
    endtask

    task automatic test_idle();
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL idle_zero_input: got %0d active cycles expected 0", bad); end
        capture_en = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            test_data_in = 32'hA5A5_0000 ^ 32'(i * 7 + 1);
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL idle_capture_off: got %0d active cycles expected 0", bad); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL idle_overflow: got %b expected 0", overflow); end
        capture_en = 1'b1;
    endtask

    task automatic test_overflow();
        logic [31:0] w [6];
        w = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 32'h01234567, 32'h89ABCDEF};
        do_reset();
        rec_on = 1'b1;
        for (int i = 0; i < 6; i++) begin
            test_data_in = w[i];
            @(negedge clk);
        end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        n_checks++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL ovf_drop_count: got %0d expected 1", drop_count); end
        n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d expected 4", fifo_level); end
        repeat (900) @(negedge clk);
        rec_on = 1'b0;
        decode_rec();
        n_checks++; if (dec_n != 5) begin n_fail++; $display("FAIL ovf_word_count: got %0d expected 5", dec_n); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (dec_words[i] !== w[i]) begin n_fail++; $display("FAIL ovf_word%0d: got %h expected %h", i, dec_words[i], w[i]); end
        end
        n_checks++; if (dec_ferr != 0) begin n_fail++; $display("FAIL ovf_framing: got %0d errors expected 0", dec_ferr); end
        n_checks++; if ({busy, fifo_level} !== 4'b0000) begin n_fail++; $display("FAIL ovf_drained: got busy=%b level=%0d expected 0/0", busy, fifo_level); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 320; i++) begin
            test_data_in = 32'h1000_0000 + 32'(i);
            @(negedge clk);
            if (i == 14) begin
                n_checks++; if (drop_count !== 8'd10) begin n_fail++; $display("FAIL sat_early_count: got %0d expected 10", drop_count); end
            end
        end
        n_checks++; if (drop_count !== 8'd255) begin n_fail++; $display("FAIL sat_count: got %0d expected 255", drop_count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sat_overflow: got %b expected 1", overflow); end
        test_data_in = 32'h2000_0000;
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clear_vs_drop_overflow: got %b expected 0", overflow); end
        n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL clear_vs_drop_count: got %0d expected 0", drop_count); end
    endtask

    task automatic test_reset_mid();
        int bad;
        do_reset();
        test_data_in = 32'hAABBCCDD;
        repeat (10) @(negedge clk);
        test_data_in = 32'h01020304;
        repeat (86) @(negedge clk);
        n_checks++; if ({tx, busy, fifo_level} !== 5'b01001) begin n_fail++; $display("FAIL midrst_pre: got tx=%b busy=%b level=%0d expected 0/1/1", tx, busy, fifo_level); end
        #2;
        rst = 1'b0;
        test_data_in = '0;
        #1;
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL midrst_tx: got %b expected 1", tx); end
        n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL midrst_level: got %0d expected 0", fifo_level); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL midrst_idle_after: got %0d active cycles expected 0", bad); end
        test_data_in = 32'h000000A5;
        rec_on = 1'b1;
        repeat (170) @(negedge clk);
        rec_on = 1'b0;
        decode_rec();
        n_checks++; if (dec_n != 1 || dec_words[0] !== 32'h000000A5) begin n_fail++; $display("FAIL midrst_new_word: got n=%0d word=%h expected 1/000000a5", dec_n, dec_words[0]); end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] w [6];
        w = '{32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003, 32'hCAFE0004, 32'hCAFE0005, 32'hBEEF0006};
        do_reset();
        rec_on = 1'b1;
        for (int i = 0; i < 5; i++) begin
            test_data_in = w[i];
            @(negedge clk);
        end
        repeat (157) @(negedge clk);
        n_checks++; if ({busy, fifo_level} !== 4'b0100) begin n_fail++; $display("FAIL ppf_before: got busy=%b level=%0d expected 0/4", busy, fifo_level); end
        test_data_in = w[5];
        @(negedge clk);
        n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ppf_level: got %0d expected 4", fifo_level); end
        n_checks++; if ({overflow, drop_count} !== 9'd0) begin n_fail++; $display("FAIL ppf_no_drop: got ovf=%b drops=%0d expected 0/0", overflow, drop_count); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ppf_busy: got %b expected 1", busy); end
        repeat (850) @(negedge clk);
        rec_on = 1'b0;
        decode_rec();
        n_checks++; if (dec_n != 6) begin n_fail++; $display("FAIL ppf_word_count: got %0d expected 6", dec_n); end
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (dec_words[i] !== w[i]) begin n_fail++; $display("FAIL ppf_word%0d: got %h expected %h", i, dec_words[i], w[i]); end
        end
        n_checks++; if (dec_ferr != 0) begin n_fail++; $display("FAIL ppf_framing: got %0d errors expected 0", dec_ferr); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_idle();
        test_overflow();
        test_saturation();
        test_reset_mid();
        test_push_pop_full();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
